// File: rtl/psum_drain_requant.sv
// Accumulates 48 signed partial sums over a programmable number of passes, then requantizes the
// finished tile to int8 and drains it lane by lane while the next tile keeps accumulating.
module psum_drain_requant #(
  parameter int NUM_MAC = 12,
  parameter int NUM_OUT = 4,
  parameter int PSUM_W  = 20,
  parameter int ACC_W   = 26,
  parameter int OUT_W   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              iBank_vld,
  input  logic [NUM_MAC*NUM_OUT*PSUM_W-1:0] iPsum,
  input  logic [5:0]                        iCfg_pass,
  input  logic [4:0]                        iCfg_shift,
  input  logic                              iCfg_relu,
  output logic                              oAcc_rdy,
  output logic                              oVld,
  input  logic                              iRdy,
  output logic [NUM_OUT*OUT_W-1:0]          oData,
  output logic [3:0]                        oLane,
  output logic                              oLast,
  output logic                              oErr_ovf
);

  localparam int NUM_ACC = NUM_MAC * NUM_OUT;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;
  localparam logic [3:0] LAST_LANE = 4'(NUM_MAC - 1);
  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] Q_MIN = -Q_MAX - (ACC_W+1)'(1);

  logic signed [ACC_W-1:0] acc_q  [NUM_ACC];
  logic signed [ACC_W-1:0] hold_q [NUM_ACC];
  logic signed [PSUM_W-1:0] psum  [NUM_ACC];
  logic signed [ACC_W-1:0] accBase [NUM_ACC];
  logic signed [ACC_W-1:0] beatSum [NUM_ACC];

  logic [5:0] pass_cnt_q, pass_cnt_d;
  logic [5:0] cfg_pass_q;
  logic [4:0] cfg_shift_q, hold_shift_q;
  logic       cfg_relu_q, hold_relu_q;
  logic [0:0] state_q, state_d;
  logic [3:0] lane_q, lane_d;
  logic       err_q;

  logic       firstBeat, holdFull, drainDone, accept, finalBeat;
  logic [5:0] tilePass;
  logic [4:0] tileShift;
  logic       tileRelu;

  // The first beat of a tile latches its config, so until then the live inputs define the tile.
  assign firstBeat = (pass_cnt_q == 6'd0);
  assign tilePass  = firstBeat ? iCfg_pass  : cfg_pass_q;
  assign tileShift = firstBeat ? iCfg_shift : cfg_shift_q;
  assign tileRelu  = firstBeat ? iCfg_relu  : cfg_relu_q;

  assign holdFull  = (state_q == ST_DRAIN);
  assign oVld      = holdFull;
  assign oLane     = lane_q;
  assign oLast     = holdFull && (lane_q == LAST_LANE);
  assign oErr_ovf  = err_q;
  assign drainDone = oVld & iRdy & oLast;
  assign oAcc_rdy  = !holdFull | (pass_cnt_q != tilePass) | drainDone;
  assign accept    = iBank_vld & oAcc_rdy;
  assign finalBeat = accept & (pass_cnt_q == tilePass);

  always_comb begin
    for (int i = 0; i < NUM_ACC; i++) begin
      psum[i]    = iPsum[i*PSUM_W +: PSUM_W];
      accBase[i] = firstBeat ? '0 : acc_q[i];
      beatSum[i] = accBase[i] + ACC_W'(psum[i]);
    end
  end

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    if (accept) begin
      pass_cnt_d = finalBeat ? 6'd0 : pass_cnt_q + 6'd1;
    end
  end

  // A lane-11 accept that coincides with a new tile landing in the hold buffer restarts at lane 0.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      ST_IDLE: begin
        if (finalBeat) begin
          state_d = ST_DRAIN;
          lane_d  = 4'd0;
        end
      end
      default: begin
        if (oVld && iRdy) begin
          if (lane_q == LAST_LANE) begin
            lane_d  = 4'd0;
            state_d = finalBeat ? ST_DRAIN : ST_IDLE;
          end else begin
            lane_d = lane_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc_q[i]  <= '0;
        hold_q[i] <= '0;
      end
      pass_cnt_q   <= '0;
      cfg_pass_q   <= '0;
      cfg_shift_q  <= '0;
      cfg_relu_q   <= 1'b0;
      hold_shift_q <= '0;
      hold_relu_q  <= 1'b0;
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      if (accept && firstBeat) begin
        cfg_pass_q  <= iCfg_pass;
        cfg_shift_q <= iCfg_shift;
        cfg_relu_q  <= iCfg_relu;
      end
      if (finalBeat) begin
        for (int i = 0; i < NUM_ACC; i++) begin
          hold_q[i] <= beatSum[i];
        end
        hold_shift_q <= tileShift;
        hold_relu_q  <= tileRelu;
      end else if (accept) begin
        for (int i = 0; i < NUM_ACC; i++) begin
          acc_q[i] <= beatSum[i];
        end
      end
      if (iBank_vld && !oAcc_rdy) begin
        err_q <= 1'b1;
      end
      pass_cnt_q <= pass_cnt_d;
      state_q    <= state_d;
      lane_q     <= lane_d;
    end
  end

  logic signed [ACC_W:0] wide [NUM_OUT];
  logic signed [ACC_W:0] rnd  [NUM_OUT];
  logic signed [ACC_W:0] rq   [NUM_OUT];
  logic signed [ACC_W:0] sat  [NUM_OUT];

  // One extra bit of headroom keeps the rounding add from wrapping at the top of the acc range.
  always_comb begin
    oData = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      wide[k] = {hold_q[int'(lane_q)*NUM_OUT + k][ACC_W-1], hold_q[int'(lane_q)*NUM_OUT + k]};
      rnd[k]  = (hold_shift_q == 5'd0) ? '0 : ((ACC_W+1)'(1) << (hold_shift_q - 5'd1));
      rq[k]   = (wide[k] + rnd[k]) >>> hold_shift_q;
      if (hold_relu_q && rq[k][ACC_W]) begin
        rq[k] = '0;
      end
      if (rq[k] > Q_MAX) begin
        sat[k] = Q_MAX;
      end else if (rq[k] < Q_MIN) begin
        sat[k] = Q_MIN;
      end else begin
        sat[k] = rq[k];
      end
      oData[k*OUT_W +: OUT_W] = sat[k][OUT_W-1:0];
    end
  end

endmodule
